// File: rtl/player_missile_pool_pkg.sv
// Shared game definitions: coordinate width, colours and the missile slot record.
package player_missile_pool_pkg;

  localparam int         COORD_W           = 11;
  localparam logic [7:0] MISSILE_COLOR_DEF = 8'hFC;
  localparam logic [7:0] TRANSPARENT       = 8'hFF;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   active;
    coord_t x;
    coord_t y;
  } slot_t;

  // Index width for a pool of n slots, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/player_missile_pool_if.sv
// Bus between the game logic and the missile pool, plus the slot state made visible for checkers.
interface player_missile_pool_if #(
  parameter int MAX_MISSILES = 4
);
  import player_missile_pool_pkg::*;

  localparam int IDX_W = idx_w(MAX_MISSILES);

  logic                     startOfFrame;
  logic                     shooting_pusle;
  logic                     collision;
  logic [COORD_W-1:0]       pixelX;
  logic [COORD_W-1:0]       pixelY;
  coord_t                   spaceShip_X;
  coord_t                   spaceShip_Y;
  logic                     missleDR;
  logic [7:0]               missleRGB;
  logic                     shot_dropped;
  slot_t [MAX_MISSILES-1:0] dbg_slots;
  logic [IDX_W-1:0]         dbg_hit_idx;

  // All inputs are sampled on every rising clk; there is no backpressure.
  modport master (
    output startOfFrame, shooting_pusle, collision, pixelX, pixelY, spaceShip_X, spaceShip_Y,
    input  missleDR, missleRGB, shot_dropped, dbg_slots, dbg_hit_idx
  );

  modport slave (
    input  startOfFrame, shooting_pusle, collision, pixelX, pixelY, spaceShip_X, spaceShip_Y,
    output missleDR, missleRGB, shot_dropped, dbg_slots, dbg_hit_idx
  );

endinterface

// File: rtl/player_missile_pool_hit_rect.sv
// Does the current scan pixel fall inside one missile's sprite rectangle.
module missile_hit_rect
  import player_missile_pool_pkg::*;
#(
  parameter int MISSILE_W = 4,
  parameter int MISSILE_H = 16
) (
  input  slot_t              slot_i,
  input  logic [COORD_W-1:0] pixel_x_i,
  input  logic [COORD_W-1:0] pixel_y_i,
  output logic               hit_o
);

  localparam logic signed [COORD_W+1:0] W_EXT = MISSILE_W;
  localparam logic signed [COORD_W+1:0] H_EXT = MISSILE_H;

  // Two extra bits: pixels are unsigned, slot corners may be negative, and x+W must not wrap.
  logic signed [COORD_W+1:0] px, py, x0, y0;

  assign px = $signed({2'b00, pixel_x_i});
  assign py = $signed({2'b00, pixel_y_i});
  assign x0 = {{2{slot_i.x[COORD_W-1]}}, slot_i.x};
  assign y0 = {{2{slot_i.y[COORD_W-1]}}, slot_i.y};

  assign hit_o = slot_i.active
              && (px >= x0) && (px < x0 + W_EXT)
              && (py >= y0) && (py < y0 + H_EXT);

endmodule

// File: rtl/player_missile_pool.sv
// Fixed pool of player missiles: spawn at the ship, climb once per frame, draw, retire on hit or off-screen.
module player_missile_pool
  import player_missile_pool_pkg::*;
#(
  parameter int         MAX_MISSILES  = 4,
  parameter int         MISSILE_W     = 4,
  parameter int         MISSILE_H     = 16,
  parameter int         SPEED         = 8,
  parameter int         SHIP_W        = 32,
  parameter logic [7:0] MISSILE_COLOR = MISSILE_COLOR_DEF
) (
  input logic                 clk,
  input logic                 resetN,
  player_missile_pool_if.slave bus
);

  localparam int     IDX_W    = idx_w(MAX_MISSILES);
  localparam coord_t SPAWN_DX = coord_t'((SHIP_W - MISSILE_W) / 2);
  localparam coord_t SPAWN_DY = coord_t'(MISSILE_H);
  localparam coord_t STEP_Y   = coord_t'(SPEED);
  localparam coord_t OFF_Y    = coord_t'(-MISSILE_H);

  slot_t [MAX_MISSILES-1:0] slots_q, slots_d;
  logic  [MAX_MISSILES-1:0] hits;
  logic                     dr_q, dr_d;
  logic                     dropped_q, dropped_d;
  logic  [IDX_W-1:0]        hit_idx_q, hit_idx_d;
  logic  [IDX_W-1:0]        free_idx;
  logic                     free_found;
  logic                     retire;

  for (genvar g = 0; g < MAX_MISSILES; g++) begin : g_rect
    missile_hit_rect #(
      .MISSILE_W (MISSILE_W),
      .MISSILE_H (MISSILE_H)
    ) u_rect (
      .slot_i    (slots_q[g]),
      .pixel_x_i (bus.pixelX),
      .pixel_y_i (bus.pixelY),
      .hit_o     (hits[g])
    );
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit_idx_d  = '0;
    for (int i = MAX_MISSILES - 1; i >= 0; i--) begin
      if (!slots_q[i].active) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (hits[i]) hit_idx_d = IDX_W'(i);
    end
    dr_d      = |hits;
    dropped_d = bus.shooting_pusle && !free_found;
    retire    = bus.collision && dr_q;
  end

  // A spawned slot was inactive and a retired slot was active, so the three updates never collide.
  always_comb begin
    coord_t ny;
    ny      = '0;
    slots_d = slots_q;
    for (int i = 0; i < MAX_MISSILES; i++) begin
      if (slots_q[i].active) begin
        if (retire && hit_idx_q == IDX_W'(i)) begin
          slots_d[i].active = 1'b0;
        end else if (bus.startOfFrame) begin
          ny                = slots_q[i].y - STEP_Y;
          slots_d[i].y      = ny;
          slots_d[i].active = !(ny < OFF_Y);
        end
      end
      if (bus.shooting_pusle && free_found && free_idx == IDX_W'(i)) begin
        slots_d[i].active = 1'b1;
        slots_d[i].x      = bus.spaceShip_X + SPAWN_DX;
        slots_d[i].y      = bus.spaceShip_Y - SPAWN_DY;
      end
    end
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      slots_q   <= '0;
      dr_q      <= 1'b0;
      hit_idx_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      slots_q   <= slots_d;
      dr_q      <= dr_d;
      hit_idx_q <= hit_idx_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.missleDR     = dr_q;
  assign bus.missleRGB    = dr_q ? MISSILE_COLOR : TRANSPARENT;
  assign bus.shot_dropped = dropped_q;
  assign bus.dbg_slots    = slots_q;
  assign bus.dbg_hit_idx  = hit_idx_q;

endmodule

// File: tb/tb_player_missile_pool.sv
// Directed bench for player_missile_pool: spawn, drop, flight, hit draw, collision retire and reset.
module tb_player_missile_pool;
  import player_missile_pool_pkg::*;

  logic clk;
  logic resetN;
  int   pass_cnt;
  int   total_cnt;

  player_missile_pool_if #(.MAX_MISSILES(4)) bus ();

  player_missile_pool dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_slot(input string tag, input int idx, input int act, input int x, input int y);
    chk({tag, ".active"}, 32'(bus.dbg_slots[idx].active), act);
    chk({tag, ".x"}, 32'(bus.dbg_slots[idx].x), x);
    chk({tag, ".y"}, 32'(bus.dbg_slots[idx].y), y);
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ship(input int sx, input int sy);
    bus.spaceShip_X = coord_t'(sx);
    bus.spaceShip_Y = coord_t'(sy);
  endtask

  task automatic set_pix(input int px, input int py);
    bus.pixelX = 11'(px);
    bus.pixelY = 11'(py);
  endtask

  task automatic fire(input int sx, input int sy);
    set_ship(sx, sy);
    bus.shooting_pusle = 1'b1;
    step();
    bus.shooting_pusle = 1'b0;
  endtask

  task automatic frame();
    bus.startOfFrame = 1'b1;
    step();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    step();
    resetN = 1'b0;
    step();
  endtask

  initial begin
    pass_cnt           = 0;
    total_cnt          = 0;
    resetN             = 1'b1;
    bus.startOfFrame   = 1'b0;
    bus.shooting_pusle = 1'b0;
    bus.collision      = 1'b0;
    set_pix(2000, 2000);
    set_ship(0, 0);

    // Reset state
    step();
    step();
    for (int i = 0; i < 4; i++) chk_slot($sformatf("rst.slot%0d", i), i, 0, 0, 0);
    chk("rst.dr", 32'(bus.missleDR), 0);
    chk("rst.rgb", 32'(bus.missleRGB), 255);
    chk("rst.dropped", 32'(bus.shot_dropped), 0);
    chk("rst.hit_idx", 32'(bus.dbg_hit_idx), 0);
    resetN = 1'b0;
    step();

    // Spawn at ship (300,400) then one frame
    fire(300, 400);
    chk_slot("spawn.slot0", 0, 1, 314, 384);
    chk("spawn.slot1.active", 32'(bus.dbg_slots[1].active), 0);
    frame();
    chk_slot("move.slot0", 0, 1, 314, 376);

    // Five back-to-back fire pulses, ship moving each time
    do_reset();
    bus.shooting_pusle = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_ship(100 + 10 * k, 300);
      step();
      if (k == 3) chk("fill4.dropped", 32'(bus.shot_dropped), 0);
      if (k == 4) chk("fill5.dropped", 32'(bus.shot_dropped), 1);
    end
    bus.shooting_pusle = 1'b0;
    step();
    chk("fill.dropped_clear", 32'(bus.shot_dropped), 0);
    for (int k = 0; k < 4; k++) chk_slot($sformatf("fill.slot%0d", k), k, 1, 114 + 10 * k, 284);

    // Asynchronous reset mid-flight clears without a clock edge
    @(negedge clk);
    resetN = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) chk_slot($sformatf("async.slot%0d", k), k, 0, 0, 0);
    @(posedge clk);
    #1;
    resetN = 1'b0;
    set_pix(114, 284);
    step();
    step();
    chk("async.dr_after", 32'(bus.missleDR), 0);
    set_pix(2000, 2000);

    // Flight off the top: y 0 -> -8 -> -16 (alive) -> -24 (gone)
    do_reset();
    fire(0, 16);
    chk_slot("top.spawn", 0, 1, 14, 0);
    frame();
    frame();
    chk_slot("top.f2", 0, 1, 14, -16);
    frame();
    chk_slot("top.f3", 0, 0, 14, -24);

    // Drawing, rectangle edges and collision retire
    do_reset();
    fire(300, 400);
    fire(500, 400);
    set_pix(316, 384);
    step();
    chk("draw.dr", 32'(bus.missleDR), 1);
    chk("draw.rgb", 32'(bus.missleRGB), 252);
    chk("draw.idx", 32'(bus.dbg_hit_idx), 0);
    bus.collision = 1'b1;
    set_pix(2000, 2000);
    step();
    bus.collision = 1'b0;
    chk_slot("hit.slot0", 0, 0, 314, 384);
    chk_slot("hit.slot1", 1, 1, 514, 384);
    chk("hit.rgb_clear", 32'(bus.missleRGB), 255);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    chk("nodr_collision.slot1", 32'(bus.dbg_slots[1].active), 1);
    set_pix(517, 399);
    step();
    chk("edge.inside_dr", 32'(bus.missleDR), 1);
    chk("edge.inside_idx", 32'(bus.dbg_hit_idx), 1);
    set_pix(518, 384);
    step();
    chk("edge.right_dr", 32'(bus.missleDR), 0);
    set_pix(514, 400);
    step();
    chk("edge.bottom_dr", 32'(bus.missleDR), 0);
    set_pix(513, 384);
    step();
    chk("edge.left_dr", 32'(bus.missleDR), 0);

    // Collision retire and frame together on slot1 at y=200
    do_reset();
    fire(300, 216);
    fire(500, 216);
    set_pix(514, 200);
    step();
    chk("cf.idx", 32'(bus.dbg_hit_idx), 1);
    bus.collision    = 1'b1;
    bus.startOfFrame = 1'b1;
    step();
    bus.collision    = 1'b0;
    bus.startOfFrame = 1'b0;
    set_pix(2000, 2000);
    chk_slot("cf.slot1", 1, 0, 514, 200);
    chk_slot("cf.slot0", 0, 1, 314, 192);

    // Fire and frame together: new missile keeps its spawn y
    set_ship(300, 416);
    bus.shooting_pusle = 1'b1;
    bus.startOfFrame   = 1'b1;
    step();
    bus.shooting_pusle = 1'b0;
    bus.startOfFrame   = 1'b0;
    chk_slot("ff.slot1", 1, 1, 314, 400);
    chk_slot("ff.slot0", 0, 1, 314, 184);

    // Fire and retire together with a full pool: retired slot not reused
    fire(600, 416);
    fire(600, 416);
    chk("full.slot3", 32'(bus.dbg_slots[3].active), 1);
    set_pix(314, 184);
    step();
    chk("fr.dr", 32'(bus.missleDR), 1);
    set_pix(2000, 2000);
    set_ship(900, 416);
    bus.collision      = 1'b1;
    bus.shooting_pusle = 1'b1;
    step();
    bus.collision      = 1'b0;
    bus.shooting_pusle = 1'b0;
    chk("fr.dropped", 32'(bus.shot_dropped), 1);
    chk_slot("fr.slot0", 0, 0, 314, 184);
    step();
    chk("fr.slot0_still_free", 32'(bus.dbg_slots[0].active), 0);
    chk("fr.dropped_clear", 32'(bus.shot_dropped), 0);

    // Report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/player_missile_pool.md
PLAYER_MISSILE_POOL -- requirements
Module: player_missile_pool

Interface
REQ-001 Parameter MAX_MISSILES, default 4: number of missile slots.
REQ-002 Parameter MISSILE_W, default 4, and MISSILE_H, default 16: missile sprite size in pixels.
REQ-003 Parameter SPEED, default 8: upward pixels per frame.
REQ-004 Parameter SHIP_W, default 32: ship width, used to centre the spawn point.
REQ-005 Parameter MISSILE_COLOR, default 8'hFC: RGB332 fill colour.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port resetN, input, 1 bit: reset, asynchronous and active-high (port name kept per codebase convention).
REQ-008 Port startOfFrame, input, 1 bit: one-cycle pulse, once per frame.
REQ-009 Port shooting_pusle, input, 1 bit: one-cycle fire request from the shooting cooldown stage.
REQ-010 Port collision, input, 1 bit: current missile pixel overlaps an enemy or obstacle.
REQ-011 Port pixelX, input, 11 bits, and port pixelY, input, 11 bits: current scan pixel.
REQ-012 Port spaceShip_X, input, signed 11 bits, and port spaceShip_Y, input, signed 11 bits: ship top-left corner.
REQ-013 Port missleDR, output, 1 bit: a missile pixel is being drawn.
REQ-014 Port missleRGB, output, 8 bits: pixel colour.
REQ-015 Port shot_dropped, output, 1 bit: one-cycle pulse when a fire request finds no free slot.

Function
REQ-016 Each slot SHALL hold: active (1 bit), x (signed 11 bits), y (signed 11 bits).
REQ-017 On shooting_pusle, the lowest-index inactive slot SHALL activate with x = spaceShip_X + (SHIP_W-MISSILE_W)/2 and y = spaceShip_Y - MISSILE_H, effective the next cycle.
REQ-018 Free-slot selection SHALL use the register state before the current cycle's updates.
REQ-019 If all slots are active on shooting_pusle, no slot SHALL change, and shot_dropped SHALL pulse high for exactly one cycle.
REQ-020 On startOfFrame, every active slot SHALL update y <= y - SPEED, using signed 11-bit arithmetic.
REQ-021 A slot whose new y is less than -MISSILE_H SHALL become inactive in the same update (fully off screen).
REQ-022 Hit test per slot: active && pixelX in [x, x+MISSILE_W) && pixelY in [y, y+MISSILE_H), compared as signed values.
REQ-023 missleDR SHALL be the registered OR of all hit tests (latency 1 cycle); the index of the lowest hitting slot SHALL be registered alongside it.
REQ-024 missleRGB SHALL be MISSILE_COLOR when missleDR is high, else 8'hFF (transparent).
REQ-025 When collision and missleDR are both high, the slot at the registered hit index SHALL become inactive next cycle.
REQ-026 When collision is high and missleDR is low, collision SHALL be ignored.
REQ-027 Collision retire and startOfFrame in the same cycle on one slot: retire wins, no move.
REQ-028 shooting_pusle and startOfFrame in the same cycle: the new missile SHALL NOT be moved in that frame.
REQ-029 shooting_pusle and collision retire in the same cycle: the retired slot SHALL NOT be reused that cycle; allocation per REQ-018.

Reset
REQ-030 While resetN is asserted: all slots inactive, x = y = 0, missleDR = 0, missleRGB = 8'hFF, shot_dropped = 0, hit index = 0.
REQ-031 Reset mid-flight SHALL clear all missiles immediately and asynchronously, with no pending spawn retained.

Structure
REQ-032 MISSILE_COLOR, the transparent colour 8'hFF, and the coordinate width 11 SHALL reside in the shared game package.
REQ-033 The per-slot hit-test rectangle SHALL be one sub-module, missile_hit_rect, instantiated MAX_MISSILES times.

Verification
REQ-034 Reset, then shooting_pusle with ship at (300,400): slot0 active at x=314, y=384; after 1 startOfFrame, y=376.
REQ-035 Five pulses with no frames in between: slots 0..3 filled; 5th pulse gives shot_dropped=1 for one cycle, and the slot state is unchanged.
REQ-036 Missile at y=0 after 2 frames (y=-16, still active); the 3rd frame gives y=-24 and the slot inactive.
REQ-037 Scan pixel (316,384) with slot0 at (314,384): missleDR=1, RGB=8'hFC one cycle later; assert collision that cycle: slot0 inactive next cycle, while others are unaffected.
REQ-038 Collision and startOfFrame in the same cycle on slot1 at y=200: slot1 inactive, y unchanged at 200.
REQ-039 Assert resetN with 3 missiles active mid-frame: all inactive immediately; missleDR=0 on the next scan.
